// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   INSTR_W / ADDR_W   : instruction and address widths
//   NOP_INSTR          : encoding placed in IF/ID for a bubble
//   DEFAULT_RESET_PC   : default first fetch address
//   fetch_state_t      : fetch FSM states (FETCH / HOLD / DISCARD)
//   ifid_ctl_t         : IF/ID register control (keep / load / bubble)
//   next_pc()          : PC + 4, wrapping modulo 2^32
package if_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = '0;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        IFID_KEEP   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctl_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request bus.
//   imem_req   : fetch request (driven by the fetch stage)
//   imem_addr  : fetch address
//   imem_ack   : rdata valid this cycle (driven by memory)
//   imem_rdata : instruction word
// Handshake: a word transfers on every cycle where imem_req and imem_ack are
// both 1; ack may arrive in the same cycle req rises (zero-wait). While
// imem_req=1 and no ack has been seen, imem_addr is held stable. The
// requester may drop imem_req without an ack only through reset.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset        : clock, synchronous active-high reset
//   ctl               : KEEP holds, LOAD captures instr_in/pc4_in, BUBBLE inserts a NOP
//   instr_in, pc4_in  : word and PC+4 to capture on LOAD
//   instr_ID, pcPlus4_ID, valid_ID : register contents presented to decode
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  ifid_ctl_t          ctl,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc4_in,
    output logic [INSTR_W-1:0] instr_ID,
    output logic [ADDR_W-1:0]  pcPlus4_ID,
    output logic               valid_ID
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_ID   <= NOP_INSTR;
            pcPlus4_ID <= '0;
            valid_ID   <= 1'b0;
        end else begin
            case (ctl)
                IFID_LOAD: begin
                    instr_ID   <= instr_in;
                    pcPlus4_ID <= pc4_in;
                    valid_ID   <= 1'b1;
                end
                IFID_BUBBLE: begin
                    instr_ID   <= NOP_INSTR;
                    pcPlus4_ID <= '0;
                    valid_ID   <= 1'b0;
                end
                default: begin
                    instr_ID   <= instr_ID;
                    pcPlus4_ID <= pcPlus4_ID;
                    valid_ID   <= valid_ID;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register. Owns the PC.
//   clk, reset     : clock, synchronous active-high reset
//   IF_ID_stall    : hold IF/ID and PC
//   redirect_ID    : taken branch/jump resolved in ID (honoured only when not stalled)
//   target_ID      : redirect target
//   imem           : instruction-memory request bus (master side)
//   instr_ID, pcPlus4_ID, valid_ID : IF/ID contents for decode
//   state_dbg      : current fetch FSM state
// A word acked while ID is stalled is parked in a one-entry hold buffer
// (HOLD). A redirect that arrives while a fetch is still un-acked leaves that
// request on the bus until it completes, then throws the word away (DISCARD).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IF_ID_stall,
    input  logic               redirect_ID,
    input  logic [ADDR_W-1:0]  target_ID,
    if_stage_if.master         imem,
    output logic [INSTR_W-1:0] instr_ID,
    output logic [ADDR_W-1:0]  pcPlus4_ID,
    output logic               valid_ID,
    output fetch_state_t       state_dbg
);

    fetch_state_t       state, state_n;
    logic [ADDR_W-1:0]  pc_f, pc_n;
    logic [ADDR_W-1:0]  discard_pc, discard_pc_n;
    logic [INSTR_W-1:0] hold_instr, hold_instr_n;
    logic [ADDR_W-1:0]  hold_pc4, hold_pc4_n;

    ifid_ctl_t          ifid_ctl;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc4;

    logic adv;
    logic [ADDR_W-1:0] pc_plus4;

    assign adv       = !IF_ID_stall;
    assign pc_plus4  = next_pc(pc_f);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc_f       <= RESET_PC;
            discard_pc <= '0;
            hold_instr <= '0;
            hold_pc4   <= '0;
        end else begin
            state      <= state_n;
            pc_f       <= pc_n;
            discard_pc <= discard_pc_n;
            hold_instr <= hold_instr_n;
            hold_pc4   <= hold_pc4_n;
        end
    end

    always_comb begin
        state_n        = state;
        pc_n           = pc_f;
        discard_pc_n   = discard_pc;
        hold_instr_n   = hold_instr;
        hold_pc4_n     = hold_pc4;
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc_f;
        ifid_ctl       = IFID_KEEP;
        ifid_instr     = imem.imem_rdata;
        ifid_pc4       = pc_plus4;

        case (state)
            FETCH: begin
                if (adv && redirect_ID) begin
                    pc_n     = target_ID;
                    ifid_ctl = IFID_BUBBLE;
                    // The in-flight request must still complete at its old address.
                    if (!imem.imem_ack) begin
                        discard_pc_n = pc_f;
                        state_n      = DISCARD;
                    end
                end else if (adv && imem.imem_ack) begin
                    ifid_ctl = IFID_LOAD;
                    pc_n     = pc_plus4;
                end else if (adv) begin
                    ifid_ctl = IFID_BUBBLE;
                end else if (imem.imem_ack) begin
                    hold_instr_n = imem.imem_rdata;
                    hold_pc4_n   = pc_plus4;
                    pc_n         = pc_plus4;
                    state_n      = HOLD;
                end
            end
            HOLD: begin
                imem.imem_req = 1'b0;
                ifid_instr    = hold_instr;
                ifid_pc4      = hold_pc4;
                if (adv && redirect_ID) begin
                    pc_n     = target_ID;
                    ifid_ctl = IFID_BUBBLE;
                    state_n  = FETCH;
                end else if (adv) begin
                    ifid_ctl = IFID_LOAD;
                    state_n  = FETCH;
                end
            end
            DISCARD: begin
                imem.imem_addr = discard_pc;
                if (imem.imem_ack) begin
                    state_n = FETCH;
                end
                if (adv) begin
                    ifid_ctl = IFID_BUBBLE;
                    if (redirect_ID) begin
                        pc_n = target_ID;
                    end
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .ctl        (ifid_ctl),
        .instr_in   (ifid_instr),
        .pc4_in     (ifid_pc4),
        .instr_ID   (instr_ID),
        .pcPlus4_ID (pcPlus4_ID),
        .valid_ID   (valid_ID)
    );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage. The reference model is the architectural
// instruction stream: the first instruction is at RESET_PC, and every
// instruction that leaves ID is followed by the one at PC+4, or by the
// redirect target if ID redirected while leaving. Memory returns
// mem_word(addr) for every acked address.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              IF_ID_stall;
    logic              redirect_ID;
    logic [31:0]       target_ID;
    logic [31:0]       instr_ID;
    logic [31:0]       pcPlus4_ID;
    logic              valid_ID;
    fetch_state_t      state_dbg;
    logic              ack_en;
    logic [31:0]       junk;

    if_stage_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA000_0003;
    endfunction

    // Memory responder: combinational, so zero-wait ack is possible.
    assign bus.imem_ack   = bus.imem_req & ack_en;
    assign bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : junk;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .IF_ID_stall (IF_ID_stall),
        .redirect_ID (redirect_ID),
        .target_ID   (target_ID),
        .imem        (bus.master),
        .instr_ID    (instr_ID),
        .pcPlus4_ID  (pcPlus4_ID),
        .valid_ID    (valid_ID),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];     // PCs of instructions expected to reach ID, in order
    logic        id_holds;     // model: ID holds a real instruction
    logic [31:0] id_pc;        // model: its PC
    int          checks;
    int          errors;
    int          delivered;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called 2 time units after a rising edge; applies inputs for the next
    // edge, updates the model for what that edge does to ID, then waits.
    task automatic drive(input logic st, input logic rd, input logic [31:0] tg, input int ack_pct);
        logic rd_eff;
        rd_eff      = rd & id_holds;
        IF_ID_stall = st;
        redirect_ID = rd_eff;
        target_ID   = tg;
        ack_en      = ($urandom_range(99) < ack_pct);
        junk        = $urandom();
        if (!reset && id_holds && !st) begin
            exp_q.push_back(rd_eff ? tg : id_pc + 32'd4);
            id_holds = 1'b0;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        exp_q.delete();
        id_holds = 1'b0;
        id_pc    = '0;
    endtask

    // ---------------- monitor: ID contents ----------------
    initial begin
        logic [31:0] e;
        logic        adv_edge;
        forever begin
            @(posedge clk);
            #1;
            // Inputs change at +2, so these are the values the edge used.
            adv_edge = !IF_ID_stall && !reset;
            if (adv_edge) begin
                if (valid_ID) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr: got pc4 %08h instr %08h, none expected", pcPlus4_ID, instr_ID);
                    end else begin
                        e = exp_q.pop_front();
                        check("id_instr", instr_ID, mem_word(e));
                        check("id_pc4", pcPlus4_ID, e + 32'd4);
                        id_holds = 1'b1;
                        id_pc    = e;
                        delivered++;
                    end
                end else begin
                    check("bubble_nop", instr_ID, 32'h0);
                end
            end else if (!reset && id_holds) begin
                check("stall_hold_valid", {31'd0, valid_ID}, 32'd1);
                check("stall_hold_instr", instr_ID, mem_word(id_pc));
            end
        end
    end

    // ---------------- monitor: request address stability ----------------
    initial begin
        logic        waiting;
        logic [31:0] wait_addr;
        waiting = 1'b0;
        wait_addr = '0;
        forever begin
            @(negedge clk);
            if (waiting && bus.imem_req) begin
                check("addr_stable", bus.imem_addr, wait_addr);
            end
            waiting   = bus.imem_req && !bus.imem_ack && !reset;
            wait_addr = bus.imem_addr;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp_disc;
        logic [31:0] tg;
        checks = 0;
        errors = 0;
        delivered = 0;
        model_reset();
        reset = 1'b1;
        IF_ID_stall = 1'b0;
        redirect_ID = 1'b0;
        target_ID = '0;
        ack_en = 1'b0;
        junk = '0;
        repeat (2) @(posedge clk);
        #2;

        // Reset state
        check("rst_req", {31'd0, bus.imem_req}, 32'd1);
        check("rst_addr", bus.imem_addr, RST_PC);
        check("rst_instr", instr_ID, 32'h0);
        check("rst_valid", {31'd0, valid_ID}, 32'd0);
        check("rst_pc4", pcPlus4_ID, 32'h0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, FETCH});

        // Zero-wait fetch: one instruction per cycle, first on the next edge
        reset = 1'b0;
        exp_q.push_back(RST_PC);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, 100);
            check("zero_wait_valid", {31'd0, valid_ID}, 32'd1);
        end

        // Stall while a word is acked: park it, drop the request
        drive(1'b1, 1'b0, '0, 100);
        check("hold_req", {31'd0, bus.imem_req}, 32'd0);
        drive(1'b1, 1'b0, '0, 100);
        check("hold_req2", {31'd0, bus.imem_req}, 32'd0);
        check("hold_state", {30'd0, state_dbg}, {30'd0, HOLD});
        drive(1'b0, 1'b0, '0, 100);

        // Redirect while the next fetch is acked: bubble, fetch target
        drive(1'b0, 1'b1, 32'h40, 100);
        check("redir_bubble", {31'd0, valid_ID}, 32'd0);
        check("redir_addr", bus.imem_addr, 32'h40);
        drive(1'b0, 1'b0, '0, 100);

        // Redirect under stall is ignored
        drive(1'b1, 1'b1, 32'h200, 100);
        drive(1'b0, 1'b0, '0, 100);

        // Redirect with the fetch un-acked: old address held until ack
        exp_disc = id_pc + 32'd4;
        drive(1'b0, 1'b1, 32'h80, 0);
        check("disc_state", {30'd0, state_dbg}, {30'd0, DISCARD});
        check("disc_addr", bus.imem_addr, exp_disc);
        check("disc_bubble", {31'd0, valid_ID}, 32'd0);
        drive(1'b0, 1'b0, '0, 0);
        check("disc_addr_hold", bus.imem_addr, exp_disc);

        // Reset during DISCARD
        reset = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, '0, 0);
        check("rst_disc_state", {30'd0, state_dbg}, {30'd0, FETCH});
        check("rst_disc_addr", bus.imem_addr, RST_PC);
        check("rst_disc_valid", {31'd0, valid_ID}, 32'd0);
        reset = 1'b0;
        exp_q.push_back(RST_PC);

        // Randomized traffic, including redirects near the 2^32 wrap
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(3))
                0:       tg = 32'hFFFF_FFF8;
                1:       tg = 32'hFFFF_FFFC;
                default: tg = $urandom() & 32'hFFFF_FFFC;
            endcase
            drive($urandom_range(99) < 25, $urandom_range(99) < 15, tg, 60);
        end

        // Drain: free-running memory, no stalls
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, '0, 100);
        end
        check("progress", {31'd0, (delivered >= 300)}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
